// File: rtl/qenc_pu_bin_fsm_pkg.sv
// Shared CABAC definitions: slice/prediction enums, context index tables,
// the PU encoder state enum and a truncated-unary length helper.
package qdec_cabac_package;

    localparam int CTX_W = 10;

    typedef enum logic [1:0] {
        SLICE_B = 2'd0,
        SLICE_P = 2'd1,
        SLICE_I = 2'd2
    } t_slice_type;

    typedef enum logic [1:0] {
        PRED_L0 = 2'd0,
        PRED_L1 = 2'd1,
        PRED_BI = 2'd2
    } t_pred_idc;

    typedef enum logic [3:0] {
        PU_IDLE           = 4'd0,
        PU_MERGE_FLAG     = 4'd1,
        PU_MERGE_IDX      = 4'd2,
        PU_INTER_PRED_IDC = 4'd3,
        PU_REF_IDX_L0     = 4'd4,
        PU_MVD_L0         = 4'd5,
        PU_MVP_L0         = 4'd6,
        PU_REF_IDX_L1     = 4'd7,
        PU_MVD_L1         = 4'd8,
        PU_MVP_L1         = 4'd9,
        PU_ENDING         = 4'd10
    } t_state_pu_enc;

    localparam logic [CTX_W-1:0] CTXIDX_MERGE_FLAG [1] = '{10'd20};
    localparam logic [CTX_W-1:0] CTXIDX_MERGE_IDX [1] = '{10'd21};
    localparam logic [CTX_W-1:0] CTXIDX_INTER_PRED_IDC [5] =
        '{10'd22, 10'd23, 10'd24, 10'd25, 10'd26};
    localparam logic [CTX_W-1:0] CTXIDX_REF_IDX [2] = '{10'd27, 10'd28};
    localparam logic [CTX_W-1:0] CTXIDX_MVP_FLAG [1] = '{10'd29};

    // Truncated unary: value ones plus a terminating zero, unless value reaches cMax.
    function automatic logic [3:0] tu_num_bins(input logic [3:0] val, input logic [3:0] cmax);
        tu_num_bins = (val >= cmax) ? cmax : (val + 4'd1);
    endfunction

endpackage

// File: rtl/qenc_pu_bin_fsm_if.sv
// Bin stream to the arithmetic-encoder core plus the MVD encoder handshake.
interface qenc_pu_bin_fsm_if #(
    parameter int CTX_AW = 10
);
    logic              bin_val;
    logic [CTX_AW-1:0] bin_ctx_addr;
    logic              bin_ep;
    logic              bin_vld;
    logic              bin_rdy;
    logic              mvd_start;
    logic              mvd_list;
    logic              mvd_done;

    modport master (
        output bin_val, bin_ctx_addr, bin_ep, bin_vld, mvd_start, mvd_list,
        input  bin_rdy, mvd_done
    );

    modport slave (
        input  bin_val, bin_ctx_addr, bin_ep, bin_vld, mvd_start, mvd_list,
        output bin_rdy, mvd_done
    );
endinterface

// File: rtl/qenc_pu_bin_fsm.sv
// Prediction-unit syntax binarizer: turns latched PU syntax into a registered
// bin stream and delegates MVD binarization to the peer MVD encoder.
module qenc_pu_bin_fsm
    import qdec_cabac_package::*;
#(
    parameter int CTX_AW = 10,
    parameter int REF_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pu_start,
    input  logic             cu_skip_flag,
    input  logic [1:0]       slice_type,
    input  logic [2:0]       maxNumMergeCand,
    input  logic [5:0]       nPbW,
    input  logic [5:0]       nPbH,
    input  logic [2:0]       split_depth,
    input  logic             merge_flag,
    input  logic [2:0]       merge_idx,
    input  logic [1:0]       inter_pred_idc,
    input  logic [REF_W-1:0] num_ref_l0_m1,
    input  logic [REF_W-1:0] num_ref_l1_m1,
    input  logic [REF_W-1:0] ref_idx_l0,
    input  logic [REF_W-1:0] ref_idx_l1,
    input  logic             mvp_l0_flag,
    input  logic             mvp_l1_flag,
    input  logic             mvd_l1_zero_flag,
    qenc_pu_bin_fsm_if.master bus,
    output logic             pu_busy,
    output logic             pu_done_intr
);

    t_state_pu_enc     r_state, w_state_nxt, w_after;
    logic [3:0]        r_cnt, w_cnt_nxt, w_nbins;
    logic              r_bin_val, r_bin_ep, r_bin_vld, r_mvd_start, r_mvd_list, r_busy, r_done;
    logic [CTX_AW-1:0] r_bin_ctx, w_ctx_nxt;
    logic              w_val_nxt, w_ep_nxt, w_vld_nxt, w_mvd_start_nxt, w_mvd_list_nxt, w_done_nxt;
    logic              w_val, w_ep;
    logic [CTX_W-1:0]  w_ctx;
    logic [2:0]        w_sd;

    logic [1:0]        r_slice, r_idc;
    logic [2:0]        r_maxm, r_midx, r_split;
    logic              r_sum12, r_mflag, r_mvp0, r_mvp1, r_mvdz;
    logic [REF_W-1:0]  r_n0, r_n1, r_ref0, r_ref1;

    // Syntax latch, captured only when a PU is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slice <= 2'd0;  r_idc  <= 2'd0;  r_maxm <= 3'd0;  r_midx <= 3'd0;
            r_split <= 3'd0;  r_sum12 <= 1'b0; r_mflag <= 1'b0;
            r_mvp0  <= 1'b0;  r_mvp1 <= 1'b0;  r_mvdz <= 1'b0;
            r_n0 <= '0; r_n1 <= '0; r_ref0 <= '0; r_ref1 <= '0;
        end else if (r_state == PU_IDLE && pu_start) begin
            r_slice <= slice_type;      r_idc  <= inter_pred_idc;
            r_maxm  <= maxNumMergeCand; r_midx <= merge_idx;
            r_split <= split_depth;     r_mflag <= merge_flag;
            r_sum12 <= (({1'b0, nPbW} + {1'b0, nPbH}) == 7'd12);
            r_mvp0  <= mvp_l0_flag;     r_mvp1 <= mvp_l1_flag;
            r_mvdz  <= mvd_l1_zero_flag;
            r_n0 <= num_ref_l0_m1; r_n1 <= num_ref_l1_m1;
            r_ref0 <= ref_idx_l0;  r_ref1 <= ref_idx_l1;
        end
    end

    assign w_sd = (r_split > 3'd3) ? 3'd3 : r_split;

    // Per-state bin descriptor: bin count, bin r_cnt's value/context, and successor state.
    always_comb begin
        w_nbins = 4'd0;
        w_val   = 1'b0;
        w_ep    = 1'b0;
        w_ctx   = '0;
        w_after = PU_ENDING;
        case (r_state)
            PU_MERGE_FLAG: begin
                w_nbins = 4'd1;
                w_val   = r_mflag;
                w_ctx   = CTXIDX_MERGE_FLAG[0];
                if (r_mflag && r_maxm > 3'd1)  w_after = PU_MERGE_IDX;
                else if (r_mflag)              w_after = PU_ENDING;
                else if (r_slice == SLICE_B)   w_after = PU_INTER_PRED_IDC;
                else                           w_after = PU_REF_IDX_L0;
            end
            PU_MERGE_IDX: begin
                w_nbins = tu_num_bins({1'b0, r_midx}, {1'b0, r_maxm - 3'd1});
                w_val   = (r_cnt < {1'b0, r_midx});
                w_ep    = (r_cnt != 4'd0);
                w_ctx   = CTXIDX_MERGE_IDX[0];
                w_after = PU_ENDING;
            end
            PU_INTER_PRED_IDC: begin
                // 8x4/4x8 PUs cannot be bi-predicted, so only the L0/L1 bin is sent.
                if (r_sum12) begin
                    w_nbins = 4'd1;
                    w_val   = (r_idc == PRED_L1);
                    w_ctx   = CTXIDX_INTER_PRED_IDC[4];
                end else begin
                    w_nbins = (r_idc == PRED_BI) ? 4'd1 : 4'd2;
                    if (r_cnt == 4'd0) begin
                        w_val = (r_idc == PRED_BI);
                        w_ctx = CTXIDX_INTER_PRED_IDC[w_sd];
                    end else begin
                        w_val = (r_idc == PRED_L1);
                        w_ctx = CTXIDX_INTER_PRED_IDC[4];
                    end
                end
                w_after = (r_idc == PRED_L1) ? PU_REF_IDX_L1 : PU_REF_IDX_L0;
            end
            PU_REF_IDX_L0, PU_REF_IDX_L1: begin
                if (r_state == PU_REF_IDX_L0) begin
                    w_nbins = tu_num_bins(4'(r_ref0), 4'(r_n0));
                    w_val   = (r_cnt < 4'(r_ref0));
                    w_after = PU_MVD_L0;
                end else begin
                    w_nbins = tu_num_bins(4'(r_ref1), 4'(r_n1));
                    w_val   = (r_cnt < 4'(r_ref1));
                    w_after = PU_MVD_L1;
                end
                w_ep  = (r_cnt > 4'd1);
                w_ctx = CTXIDX_REF_IDX[r_cnt[0]];
            end
            PU_MVP_L0: begin
                w_nbins = 4'd1;
                w_val   = r_mvp0;
                w_ctx   = CTXIDX_MVP_FLAG[0];
                w_after = (r_slice != SLICE_B || r_idc == PRED_L0) ? PU_ENDING : PU_REF_IDX_L1;
            end
            PU_MVP_L1: begin
                w_nbins = 4'd1;
                w_val   = r_mvp1;
                w_ctx   = CTXIDX_MVP_FLAG[0];
                w_after = PU_ENDING;
            end
            default: begin
                w_nbins = 4'd0;
                w_after = PU_ENDING;
            end
        endcase
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_vld_nxt       = r_bin_vld;
        w_val_nxt       = r_bin_val;
        w_ep_nxt        = r_bin_ep;
        w_ctx_nxt       = r_bin_ctx;
        w_mvd_start_nxt = 1'b0;
        w_mvd_list_nxt  = r_mvd_list;
        w_done_nxt      = 1'b0;
        case (r_state)
            PU_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (pu_start) begin
                    if (cu_skip_flag && maxNumMergeCand > 3'd1) w_state_nxt = PU_MERGE_IDX;
                    else if (cu_skip_flag)                      w_state_nxt = PU_ENDING;
                    else                                        w_state_nxt = PU_MERGE_FLAG;
                end else begin
                    w_state_nxt = PU_IDLE;
                end
            end
            PU_MVD_L0, PU_MVD_L1: begin
                if (r_state == PU_MVD_L1 && r_mvdz && r_idc == PRED_BI) begin
                    w_state_nxt = PU_MVP_L1;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_mvd_start_nxt = 1'b1;
                    w_mvd_list_nxt  = (r_state == PU_MVD_L1);
                    w_cnt_nxt       = 4'd1;
                end else if (bus.mvd_done) begin
                    w_state_nxt = (r_state == PU_MVD_L0) ? PU_MVP_L0 : PU_MVP_L1;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            PU_ENDING: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = PU_IDLE;
                w_cnt_nxt   = 4'd0;
            end
            default: begin
                // r_cnt counts bins already loaded into the output register.
                if (!r_bin_vld || bus.bin_rdy) begin
                    if (r_cnt == w_nbins) begin
                        w_vld_nxt   = 1'b0;
                        w_state_nxt = w_after;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_vld_nxt = 1'b1;
                        w_val_nxt = w_val;
                        w_ep_nxt  = w_ep;
                        w_ctx_nxt = w_ep ? '0 : CTX_AW'(w_ctx);
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else begin
                    w_vld_nxt = r_bin_vld;
                end
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PU_IDLE;
            r_cnt       <= 4'd0;
            r_bin_vld   <= 1'b0;
            r_bin_val   <= 1'b0;
            r_bin_ep    <= 1'b0;
            r_bin_ctx   <= '0;
            r_mvd_start <= 1'b0;
            r_mvd_list  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bin_vld   <= w_vld_nxt;
            r_bin_val   <= w_val_nxt;
            r_bin_ep    <= w_ep_nxt;
            r_bin_ctx   <= w_ctx_nxt;
            r_mvd_start <= w_mvd_start_nxt;
            r_mvd_list  <= w_mvd_list_nxt;
            r_busy      <= (w_state_nxt != PU_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    assign bus.bin_val      = r_bin_val;
    assign bus.bin_ctx_addr = r_bin_ctx;
    assign bus.bin_ep       = r_bin_ep;
    assign bus.bin_vld      = r_bin_vld;
    assign bus.mvd_start    = r_mvd_start;
    assign bus.mvd_list     = r_mvd_list;
    assign pu_busy          = r_busy;
    assign pu_done_intr     = r_done;

endmodule

// File: tb/tb_qenc_pu_bin_fsm.sv
// Directed bench: an event-queue model of the PU bin sequence is checked
// against the DUT every cycle, with hand-computed bin strings per PU.
module tb_qenc_pu_bin_fsm;
    import qdec_cabac_package::*;

    localparam int EV_BIN = 0, EV_MVD = 1, EV_DONE = 2;

    typedef struct {
        int kind; int val; int ep; int ctx; int list;
    } ev_t;

    typedef struct {
        int skip; int slice; int maxm; int w; int h; int sd; int mf; int midx;
        int idc; int n0; int n1; int r0; int r1; int p0; int p1; int z;
    } pu_t;

    logic       clk = 1'b0;
    logic       rst, pu_start, cu_skip_flag, merge_flag, mvp_l0_flag, mvp_l1_flag, mvd_l1_zero_flag;
    logic [1:0] slice_type, inter_pred_idc;
    logic [2:0] maxNumMergeCand, split_depth, merge_idx;
    logic [5:0] nPbW, nPbH;
    logic [3:0] num_ref_l0_m1, num_ref_l1_m1, ref_idx_l0, ref_idx_l1;
    logic       pu_busy, pu_done_intr;

    qenc_pu_bin_fsm_if #(.CTX_AW(10)) bus_if ();

    qenc_pu_bin_fsm #(.CTX_AW(10), .REF_W(4)) dut (
        .clk(clk), .rst(rst), .pu_start(pu_start), .cu_skip_flag(cu_skip_flag),
        .slice_type(slice_type), .maxNumMergeCand(maxNumMergeCand), .nPbW(nPbW), .nPbH(nPbH),
        .split_depth(split_depth), .merge_flag(merge_flag), .merge_idx(merge_idx),
        .inter_pred_idc(inter_pred_idc), .num_ref_l0_m1(num_ref_l0_m1),
        .num_ref_l1_m1(num_ref_l1_m1), .ref_idx_l0(ref_idx_l0), .ref_idx_l1(ref_idx_l1),
        .mvp_l0_flag(mvp_l0_flag), .mvp_l1_flag(mvp_l1_flag),
        .mvd_l1_zero_flag(mvd_l1_zero_flag), .bus(bus_if.master),
        .pu_busy(pu_busy), .pu_done_intr(pu_done_intr)
    );

    always #5 clk = ~clk;

    ev_t         exp_q[$];
    int          nchk = 0, nerr = 0;
    int          bins_seen = 0, mvd_seen = 0, done_seen = 0;
    logic [15:0] obs_bits = 16'd0;
    int          stall_at = -1, stall_left = 0, mvd_pending = 0;
    logic        mvd_hold = 1'b0, prev_stall = 1'b0;
    logic        s_val, s_ep;
    logic [9:0]  s_ctx;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_bin(input int v, input int ep, input int ctx);
        ev_t e;
        e.kind = EV_BIN; e.val = v; e.ep = ep; e.ctx = ctx; e.list = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_ev(input int kind, input int list);
        ev_t e;
        e.kind = kind; e.val = 0; e.ep = 0; e.ctx = 0; e.list = list;
        exp_q.push_back(e);
    endtask

    // Truncated unary with cMax; the first nctx bins are context coded.
    task automatic push_tu(input int v, input int cmax, input int nctx, input int c0, input int c1);
        for (int k = 0; k < cmax; k++) begin
            int b;
            b = (k < v) ? 1 : 0;
            push_bin(b, (k >= nctx) ? 1 : 0, (k == 0) ? c0 : c1);
            if (b == 0) break;
        end
    endtask

    task automatic model_pu(input pu_t p);
        int use0, use1;
        if (p.skip != 0 || p.mf != 0) begin
            if (p.skip == 0) push_bin(1, 0, int'(CTXIDX_MERGE_FLAG[0]));
            if (p.maxm > 1) push_tu(p.midx, p.maxm - 1, 1, int'(CTXIDX_MERGE_IDX[0]), 0);
            push_ev(EV_DONE, 0);
            return;
        end
        push_bin(0, 0, int'(CTXIDX_MERGE_FLAG[0]));
        use0 = 1; use1 = 0;
        if (p.slice == 0) begin
            use0 = (p.idc != 1);
            use1 = (p.idc != 0);
            if (p.w + p.h == 12) push_bin(p.idc == 1, 0, int'(CTXIDX_INTER_PRED_IDC[4]));
            else begin
                push_bin(p.idc == 2, 0, int'(CTXIDX_INTER_PRED_IDC[p.sd]));
                if (p.idc != 2) push_bin(p.idc == 1, 0, int'(CTXIDX_INTER_PRED_IDC[4]));
            end
        end
        if (use0 != 0) begin
            push_tu(p.r0, p.n0, 2, int'(CTXIDX_REF_IDX[0]), int'(CTXIDX_REF_IDX[1]));
            push_ev(EV_MVD, 0);
            push_bin(p.p0, 0, int'(CTXIDX_MVP_FLAG[0]));
        end
        if (use1 != 0) begin
            push_tu(p.r1, p.n1, 2, int'(CTXIDX_REF_IDX[0]), int'(CTXIDX_REF_IDX[1]));
            if (!(p.z != 0 && p.idc == 2)) push_ev(EV_MVD, 1);
            push_bin(p.p1, 0, int'(CTXIDX_MVP_FLAG[0]));
        end
        push_ev(EV_DONE, 0);
    endtask

    task automatic drive_pu(input pu_t p);
        cu_skip_flag = p.skip[0];      slice_type = p.slice[1:0];  maxNumMergeCand = p.maxm[2:0];
        nPbW = p.w[5:0];               nPbH = p.h[5:0];            split_depth = p.sd[2:0];
        merge_flag = p.mf[0];          merge_idx = p.midx[2:0];    inter_pred_idc = p.idc[1:0];
        num_ref_l0_m1 = p.n0[3:0];     num_ref_l1_m1 = p.n1[3:0];
        ref_idx_l0 = p.r0[3:0];        ref_idx_l1 = p.r1[3:0];
        mvp_l0_flag = p.p0[0];         mvp_l1_flag = p.p1[0];      mvd_l1_zero_flag = p.z[0];
        model_pu(p);
        bins_seen = 0; mvd_seen = 0; done_seen = 0; obs_bits = 16'd0;
        pu_start = 1'b1;
        @(posedge clk); #1;
        pu_start = 1'b0;
    endtask

    task automatic run_pu(input string nm, input pu_t p, input int e_bins, input int e_mvd,
                          input logic [15:0] e_bits);
        int n;
        drive_pu(p);
        n = 0;
        while (done_seen == 0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk({nm, "_done"}, done_seen, 1);
        chk({nm, "_nbins"}, bins_seen, e_bins);
        chk({nm, "_nmvd"}, mvd_seen, e_mvd);
        chk({nm, "_bits"}, int'(obs_bits), int'(e_bits));
        chk({nm, "_q_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_vld"}, int'(bus_if.bin_vld), 0);
        chk({nm, "_val"}, int'(bus_if.bin_val), 0);
        chk({nm, "_ep"}, int'(bus_if.bin_ep), 0);
        chk({nm, "_ctx"}, int'(bus_if.bin_ctx_addr), 0);
        chk({nm, "_mvd_start"}, int'(bus_if.mvd_start), 0);
        chk({nm, "_mvd_list"}, int'(bus_if.mvd_list), 0);
        chk({nm, "_busy"}, int'(pu_busy), 0);
        chk({nm, "_done"}, int'(pu_done_intr), 0);
    endtask

    // Ready/stall and MVD-encoder emulation, then per-cycle comparison against the model.
    always @(negedge clk) begin
        ev_t e;
        if (bus_if.bin_vld && stall_left > 0 && bins_seen == stall_at) begin
            bus_if.bin_rdy = 1'b0;
            stall_left--;
        end else begin
            bus_if.bin_rdy = 1'b1;
        end
        bus_if.mvd_done = 1'b0;
        if (mvd_pending > 0) begin
            mvd_pending--;
            if (mvd_pending == 0) bus_if.mvd_done = 1'b1;
        end
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_vld", int'(bus_if.bin_vld), 1);
                chk("stall_val", int'(bus_if.bin_val), int'(s_val));
                chk("stall_ep", int'(bus_if.bin_ep), int'(s_ep));
                chk("stall_ctx", int'(bus_if.bin_ctx_addr), int'(s_ctx));
            end
            prev_stall = bus_if.bin_vld && !bus_if.bin_rdy;
            s_val = bus_if.bin_val; s_ep = bus_if.bin_ep; s_ctx = bus_if.bin_ctx_addr;
            if (bus_if.bin_vld && bus_if.bin_rdy) begin
                bins_seen++;
                obs_bits = {obs_bits[14:0], bus_if.bin_val};
                if (exp_q.size() == 0 || exp_q[0].kind != EV_BIN) begin
                    chk("bin_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bin_val", int'(bus_if.bin_val), e.val);
                    chk("bin_ep", int'(bus_if.bin_ep), e.ep);
                    if (e.ep == 0) chk("bin_ctx", int'(bus_if.bin_ctx_addr), e.ctx);
                end
            end
            if (bus_if.mvd_start) begin
                mvd_seen++;
                if (!mvd_hold) mvd_pending = 3;
                if (exp_q.size() == 0 || exp_q[0].kind != EV_MVD) begin
                    chk("mvd_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mvd_list", int'(bus_if.mvd_list), e.list);
                end
            end
            if (pu_done_intr) begin
                done_seen++;
                if (exp_q.size() == 0 || exp_q[0].kind != EV_DONE) chk("done_unexpected", 1, 0);
                else e = exp_q.pop_front();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", nerr);
        $fatal(1);
    end

    initial begin
        pu_t p;
        int  n;
        rst = 1'b1; pu_start = 1'b0; cu_skip_flag = 1'b0; merge_flag = 1'b0;
        mvp_l0_flag = 1'b0; mvp_l1_flag = 1'b0; mvd_l1_zero_flag = 1'b0;
        slice_type = 2'd0; inter_pred_idc = 2'd0; maxNumMergeCand = 3'd0; split_depth = 3'd0;
        merge_idx = 3'd0; nPbW = 6'd0; nPbH = 6'd0;
        num_ref_l0_m1 = 4'd0; num_ref_l1_m1 = 4'd0; ref_idx_l0 = 4'd0; ref_idx_l1 = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_idle_outputs("reset");
        rst = 1'b0;

        p = '{skip:1, slice:0, maxm:5, w:16, h:16, sd:0, mf:0, midx:2, idc:0,
              n0:0, n1:0, r0:0, r1:0, p0:0, p1:0, z:0};
        run_pu("skip_idx2", p, 3, 0, 16'b110);
        p.midx = 4;
        run_pu("skip_idx4", p, 4, 0, 16'b1111);
        p.maxm = 1; p.midx = 0;
        run_pu("skip_max1", p, 0, 0, 16'b0);
        p = '{skip:0, slice:0, maxm:1, w:16, h:16, sd:0, mf:1, midx:0, idc:0,
              n0:0, n1:0, r0:0, r1:0, p0:0, p1:0, z:0};
        run_pu("merge_max1", p, 1, 0, 16'b1);
        p = '{skip:0, slice:0, maxm:5, w:16, h:16, sd:1, mf:0, midx:0, idc:2,
              n0:2, n1:0, r0:2, r1:0, p0:1, p1:0, z:0};
        run_pu("b_bi", p, 6, 2, 16'b011110);
        p = '{skip:0, slice:0, maxm:5, w:8, h:4, sd:0, mf:0, midx:0, idc:1,
              n0:3, n1:0, r0:1, r1:0, p0:0, p1:1, z:0};
        run_pu("b_l1_8x4", p, 3, 1, 16'b011);
        p = '{skip:0, slice:1, maxm:5, w:16, h:8, sd:0, mf:0, midx:0, idc:0,
              n0:3, n1:0, r0:1, r1:0, p0:0, p1:0, z:0};
        run_pu("p_l0", p, 4, 1, 16'b0100);
        p = '{skip:0, slice:0, maxm:5, w:32, h:32, sd:2, mf:0, midx:0, idc:2,
              n0:0, n1:4, r0:0, r1:3, p0:1, p1:1, z:1};
        run_pu("b_bi_zero", p, 8, 1, 16'b01111101);

        stall_at = 1; stall_left = 5;
        p = '{skip:1, slice:0, maxm:5, w:16, h:16, sd:0, mf:0, midx:2, idc:0,
              n0:0, n1:0, r0:0, r1:0, p0:0, p1:0, z:0};
        run_pu("stall", p, 3, 0, 16'b110);
        chk("stall_used", stall_left, 0);

        mvd_hold = 1'b1;
        p = '{skip:0, slice:0, maxm:5, w:16, h:16, sd:1, mf:0, midx:0, idc:2,
              n0:2, n1:0, r0:2, r1:0, p0:1, p1:0, z:0};
        drive_pu(p);
        n = 0;
        while (mvd_seen == 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rst_mvd_reached", mvd_seen, 1);
        chk("rst_busy_mid", int'(pu_busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk_idle_outputs("midreset");
        exp_q.delete();
        rst = 1'b0; mvd_hold = 1'b0; done_seen = 0; bins_seen = 0; mvd_seen = 0;
        repeat (12) @(negedge clk);
        #1;
        chk("rst_no_done", done_seen, 0);
        chk("rst_no_bins", bins_seen, 0);
        chk("rst_no_mvd", mvd_seen, 0);

        p = '{skip:1, slice:0, maxm:5, w:16, h:16, sd:0, mf:0, midx:2, idc:0,
              n0:0, n1:0, r0:0, r1:0, p0:0, p1:0, z:0};
        run_pu("after_rst", p, 3, 0, 16'b110);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
